// File: rtl/regfile_writeback_ctrl_pkg.sv
// Shared types and defaults for the register-file writeback controller.
// One writeback entry is {wreg, wcb, addr, data, cb}, MSB first.
package regfile_writeback_ctrl_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;
  localparam int NUM_REGS   = 8;
  localparam int DEPTH_DEF  = 4;

  typedef struct packed {
    logic                  wreg;
    logic                  wcb;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
    logic                  cb;
  } wb_entry_t;

  localparam int ENTRY_W = $bits(wb_entry_t);

  function automatic int entry_width(input int addr_w, input int data_w);
    return addr_w + data_w + 3;
  endfunction

endpackage

// File: rtl/regfile_writeback_ctrl_wb_fifo.sv
// Parameterised synchronous FIFO; push is ignored when full, pop when empty.
// head_o always shows the oldest entry (undefined content when empty).
module wb_fifo #(
  parameter int W     = 14,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [W-1:0]               din_i,
  input  logic                       pop_i,
  output logic [W-1:0]               head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din_i;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    // Push and pop together leave occupancy unchanged.
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/regfile_writeback_ctrl.sv
// Register-file writer: arbitrates ALU/load results into an in-order FIFO,
// drains one entry per cycle onto the write port and tracks pending writes.
module regfile_writeback_ctrl
  import regfile_writeback_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     alu_valid_i,
  output logic                     alu_ready_o,
  input  logic                     alu_wreg_i,
  input  logic                     alu_wcb_i,
  input  logic [ADDR_W-1:0]        alu_addr_i,
  input  logic [DATA_W-1:0]        alu_data_i,
  input  logic                     alu_cb_i,
  input  logic                     mem_valid_i,
  output logic                     mem_ready_o,
  input  logic [ADDR_W-1:0]        mem_addr_i,
  input  logic [DATA_W-1:0]        mem_data_i,
  output logic                     write_o,
  output logic [ADDR_W-1:0]        write_addr_o,
  output logic [DATA_W-1:0]        write_data_o,
  output logic                     write_CB_o,
  output logic                     cb_data_o,
  output logic [2**ADDR_W-1:0]     pending_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int NREG = 2**ADDR_W;
  localparam int EW   = entry_width(ADDR_W, DATA_W);
  localparam int PW   = $clog2(DEPTH + 2);

  // Valid/ready: a transfer happens on a rising edge where both are high.
  // Readies depend only on occupancy and mem_valid_i, so a pop in the same
  // cycle never frees a slot early and no comb path runs from pop to ready.

  logic [EW-1:0] mem_entry, alu_entry, push_entry, head;
  logic          fifo_full, fifo_empty, push, push_mem, push_alu;

  assign mem_entry = {1'b1, 1'b0, mem_addr_i, mem_data_i, 1'b0};
  assign alu_entry = {alu_wreg_i, alu_wcb_i, alu_addr_i, alu_data_i, alu_cb_i};

  assign mem_ready_o = !fifo_full;
  assign alu_ready_o = !fifo_full && !mem_valid_i;

  assign push_mem   = mem_valid_i && mem_ready_o;
  // An ALU result that writes nothing completes its handshake but is dropped.
  assign push_alu   = alu_valid_i && alu_ready_o && (alu_wreg_i || alu_wcb_i);
  assign push       = push_mem || push_alu;
  assign push_entry = push_mem ? mem_entry : alu_entry;

  wb_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .din_i   (push_entry),
    .pop_i   (!fifo_empty),
    .head_o  (head),
    .count_o (count_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  logic              write_q, write_d;
  logic              write_cb_q, write_cb_d;
  logic [ADDR_W-1:0] write_addr_q, write_addr_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic              cb_data_q, cb_data_d;

  always_comb begin
    write_d      = 1'b0;
    write_cb_d   = 1'b0;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    cb_data_d    = cb_data_q;
    if (!fifo_empty) begin
      write_d      = head[EW-1];
      write_cb_d   = head[EW-2];
      write_addr_d = head[DATA_W+ADDR_W:DATA_W+1];
      write_data_d = head[DATA_W:1];
      cb_data_d    = head[0];
    end
  end

  // A register stays pending from push until its write leaves the output stage.
  logic [PW-1:0]   pend_q [NREG];
  logic [PW-1:0]   pend_d [NREG];
  logic [NREG-1:0] inc_vec, dec_vec;

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      inc_vec[r] = push && push_entry[EW-1] &&
                   (push_entry[DATA_W+ADDR_W:DATA_W+1] == ADDR_W'(r));
      dec_vec[r] = write_q && (write_addr_q == ADDR_W'(r));
      pend_d[r]  = pend_q[r];
      if (inc_vec[r] && !dec_vec[r]) begin
        pend_d[r] = pend_q[r] + PW'(1);
      end else if (dec_vec[r] && !inc_vec[r]) begin
        pend_d[r] = pend_q[r] - PW'(1);
      end
      pending_o[r] = (pend_q[r] != '0);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      write_q      <= 1'b0;
      write_cb_q   <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
      cb_data_q    <= 1'b0;
      for (int r = 0; r < NREG; r++) begin
        pend_q[r] <= '0;
      end
    end else begin
      write_q      <= write_d;
      write_cb_q   <= write_cb_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
      cb_data_q    <= cb_data_d;
      pend_q       <= pend_d;
    end
  end

  assign write_o      = write_q;
  assign write_CB_o   = write_cb_q;
  assign write_addr_o = write_addr_q;
  assign write_data_o = write_data_q;
  assign cb_data_o    = cb_data_q;

endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
// Scoreboarded bench for regfile_writeback_ctrl: accepted results are queued
// as expected writes, a negedge monitor checks the write port against them.
module tb_regfile_writeback_ctrl;
  import regfile_writeback_ctrl_pkg::*;

  localparam int DEPTH = 4;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       alu_valid_i = 1'b0, alu_wreg_i = 1'b0, alu_wcb_i = 1'b0, alu_cb_i = 1'b0;
  logic [2:0] alu_addr_i = '0, mem_addr_i = '0;
  logic [7:0] alu_data_i = '0, mem_data_i = '0;
  logic       mem_valid_i = 1'b0;
  logic       alu_ready_o, mem_ready_o, write_o, write_CB_o, cb_data_o;
  logic [2:0] write_addr_o;
  logic [7:0] write_data_o, pending_o;
  logic [2:0] count_o;

  regfile_writeback_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o),
    .alu_wreg_i(alu_wreg_i), .alu_wcb_i(alu_wcb_i), .alu_addr_i(alu_addr_i),
    .alu_data_i(alu_data_i), .alu_cb_i(alu_cb_i),
    .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o),
    .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
    .write_o(write_o), .write_addr_o(write_addr_o), .write_data_o(write_data_o),
    .write_CB_o(write_CB_o), .cb_data_o(cb_data_o),
    .pending_o(pending_o), .count_o(count_o)
  );

  // ---------------- clock / reset block ----------------
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  logic [ENTRY_W-1:0] exp_q[$];
  logic [7:0] dut_rf [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk_i) begin
    if (write_o) dut_rf[write_addr_o] <= write_data_o;
  end

  // ---------------- scoreboard monitor ----------------
  wb_entry_t  cur;
  logic [7:0] exp_pend;

  always @(negedge clk_i) begin
    if (!rst_i && mon_en) begin
      exp_pend = '0;
      if (write_o || write_CB_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {write_o, write_CB_o}, 2'b00);
        end else begin
          cur = exp_q.pop_front();
          chk("write_o", write_o, cur.wreg);
          chk("write_CB_o", write_CB_o, cur.wcb);
          if (cur.wreg) begin
            chk("write_addr", write_addr_o, cur.addr);
            chk("write_data", write_data_o, cur.data);
            exp_pend[cur.addr] = 1'b1;
          end
          if (cur.wcb) chk("cb_data", cb_data_o, cur.cb);
        end
      end
      foreach (exp_q[i]) begin
        cur = exp_q[i];
        if (cur.wreg) exp_pend[cur.addr] = 1'b1;
      end
      chk("pending", pending_o, exp_pend);
      chk("count", count_o, exp_q.size());
      chk("count_max", count_o <= DEPTH, 1'b1);
      chk("mem_ready", mem_ready_o, exp_q.size() < DEPTH);
      chk("alu_ready", alu_ready_o, (exp_q.size() < DEPTH) && !mem_valid_i);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input bit mv, input logic [2:0] ma, input logic [7:0] md,
                       input bit av, input bit aw, input bit ac,
                       input logic [2:0] aa, input logic [7:0] ad, input bit acb);
    bit m_acc, a_acc;
    mem_valid_i = mv; mem_addr_i = ma; mem_data_i = md;
    alu_valid_i = av; alu_wreg_i = aw; alu_wcb_i = ac;
    alu_addr_i = aa; alu_data_i = ad; alu_cb_i = acb;
    for (int t = 0; t < 20 && (mem_valid_i || alu_valid_i); t++) begin
      @(negedge clk_i);
      m_acc = mem_valid_i && mem_ready_o;
      a_acc = alu_valid_i && alu_ready_o;
      @(posedge clk_i);
      if (m_acc) exp_q.push_back({1'b1, 1'b0, ma, md, 1'b0});
      if (a_acc && (aw || ac)) exp_q.push_back({aw, ac, aa, ad, acb});
      #1;
      if (m_acc) mem_valid_i = 1'b0;
      if (a_acc) alu_valid_i = 1'b0;
    end
    if (mem_valid_i || alu_valid_i) begin
      chk("handshake_timeout", {mem_valid_i, alu_valid_i}, 2'b00);
      mem_valid_i = 1'b0;
      alu_valid_i = 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset held with a load offered.
    mem_valid_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_write_o", write_o, 0);
    chk("rst_write_CB_o", write_CB_o, 0);
    chk("rst_addr", write_addr_o, 0);
    chk("rst_data", write_data_o, 0);
    chk("rst_cb_data", cb_data_o, 0);
    chk("rst_pending", pending_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_mem_ready", mem_ready_o, 1);
    mem_valid_i = 1'b0;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    mon_en = 1'b1;

    // First load: latency and pending window.
    issue(1, 3'd1, 8'h11, 0, 0, 0, 3'd0, 8'h00, 0);
    @(negedge clk_i);
    chk("lat_pend_before", pending_o, 8'h02);
    chk("lat_write_early", write_o, 0);
    @(negedge clk_i);
    chk("lat_write", write_o, 1);
    chk("lat_addr", write_addr_o, 1);
    chk("lat_data", write_data_o, 8'h11);
    chk("lat_pend_during", pending_o, 8'h02);
    @(negedge clk_i);
    chk("lat_pend_after", pending_o, 8'h00);
    idle(1);

    // Load wins over ALU; ALU follows next cycle.
    issue(1, 3'd3, 8'h33, 1, 1, 0, 3'd2, 8'h22, 0);
    idle(3);

    // CB-only ALU results.
    issue(0, 3'd0, 8'h00, 1, 0, 1, 3'd5, 8'h5a, 1);
    issue(0, 3'd0, 8'h00, 1, 0, 1, 3'd6, 8'ha5, 0);
    // ALU result writing nothing is dropped.
    issue(0, 3'd0, 8'h00, 1, 0, 0, 3'd7, 8'hff, 1);
    // Combined register + CB write.
    issue(0, 3'd0, 8'h00, 1, 1, 1, 3'd7, 8'h77, 1);
    idle(3);

    // Five loads, alternating valid.
    for (int i = 0; i < 5; i++) begin
      issue(1, 3'(i), 8'(8'h50 + i), 0, 0, 0, 3'd0, 8'h00, 0);
      if (i % 2 == 1) idle(1);
    end
    idle(3);

    // Two queued writes to r4.
    issue(1, 3'd4, 8'h40, 0, 0, 0, 3'd0, 8'h00, 0);
    issue(1, 3'd4, 8'h41, 0, 0, 0, 3'd0, 8'h00, 0);
    idle(4);
    chk("r4_final", dut_rf[4], 8'h41);

    // Randomized mix.
    for (int n = 0; n < 200; n++) begin
      issue($urandom_range(0, 1), 3'($urandom_range(0, 7)), 8'($urandom),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
            3'($urandom_range(0, 7)), 8'($urandom), $urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(4);

    // Asynchronous reset while writes are in flight.
    issue(1, 3'd1, 8'ha1, 0, 0, 0, 3'd0, 8'h00, 0);
    issue(1, 3'd2, 8'ha2, 1, 1, 1, 3'd6, 8'ha6, 1);
    #2;
    chk("pre_rst_write", write_o, 1);
    rst_i = 1'b1;
    #1;
    chk("arst_write_o", write_o, 0);
    chk("arst_write_CB_o", write_CB_o, 0);
    chk("arst_count", count_o, 0);
    chk("arst_pending", pending_o, 0);
    exp_q.delete();
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    idle(5);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
